// File: rtl/lifo_stack_p_pkg.sv
// Shared defaults and the per-cycle command encoding for the LIFO stack.
package stack_pkg;
    localparam int STACK_WIDTH_DEF = 12;
    localparam int STACK_DEPTH_DEF = 5;

    typedef enum logic [2:0] {
        OP_NOP,
        OP_PUSH,
        OP_POP,
        OP_REPLACE,
        OP_CLEAR
    } stack_op_e;
endpackage

// File: rtl/lifo_stack_p_if.sv
// Command/status bundle between a stack user (master) and the stack (slave).
interface lifo_stack_p_if
    import stack_pkg::*;
#(
    parameter int WIDTH = STACK_WIDTH_DEF,
    parameter int DEPTH = STACK_DEPTH_DEF
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             clear;
    logic             push;
    logic             pop;
    logic             err_clr;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             almost_full;
    logic             overflow;
    logic             underflow;

    modport master (
        output clear, push, pop, err_clr, data_in,
        input  data_out, count, empty, full, almost_full, overflow, underflow
    );

    modport slave (
        input  clear, push, pop, err_clr, data_in,
        output data_out, count, empty, full, almost_full, overflow, underflow
    );
endinterface

// File: rtl/lifo_stack_p_ram.sv
// Stack storage: one synchronous write port, one asynchronous read port, no reset.
module stack_ram #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 5,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/lifo_stack_p.sv
// LIFO stack: pointer, sticky error flags and command decode around stack_ram.
module lifo_stack_p
    import stack_pkg::*;
#(
    parameter int WIDTH = STACK_WIDTH_DEF,
    parameter int DEPTH = STACK_DEPTH_DEF
) (
    input  logic          clk,
    input  logic          reset_n,
    lifo_stack_p_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C = CW'(DEPTH - 1);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             empty_w, full_w;
    logic             ovf_evt, unf_evt;
    logic             wr_en;
    logic [AW-1:0]    wr_addr, rd_addr;
    logic [WIDTH-1:0] rd_data;
    stack_op_e        op;

    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == DEPTH_C);
    assign rd_addr = AW'(count_q - ONE_C);

    // push&pop on an empty stack has nothing to replace, so it degrades to a push
    always_comb begin
        op = OP_NOP;
        if (bus.clear)                 op = OP_CLEAR;
        else if (bus.push && bus.pop)  op = empty_w ? OP_PUSH : OP_REPLACE;
        else if (bus.push)             op = OP_PUSH;
        else if (bus.pop)              op = OP_POP;
    end

    assign ovf_evt = (op == OP_PUSH) && full_w;
    assign unf_evt = (op == OP_POP) && empty_w;

    always_comb begin
        count_d = count_q;
        wr_en   = 1'b0;
        wr_addr = AW'(count_q);
        unique case (op)
            OP_CLEAR: count_d = '0;
            OP_PUSH: begin
                if (!full_w) begin
                    wr_en   = 1'b1;
                    count_d = count_q + ONE_C;
                end
            end
            OP_POP: begin
                if (!empty_w) count_d = count_q - ONE_C;
            end
            OP_REPLACE: begin
                wr_en   = 1'b1;
                wr_addr = rd_addr;
            end
            default: ;
        endcase
    end

    // a coincident error event beats err_clr
    assign overflow_d  = (overflow_q  & ~bus.err_clr) | ovf_evt;
    assign underflow_d = (underflow_q & ~bus.err_clr) | unf_evt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    stack_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (wr_addr),
        .wdata_i (bus.data_in),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    // storage is unreset, so anything read while empty must be masked
    assign bus.data_out    = empty_w ? '0 : rd_data;
    assign bus.count       = count_q;
    assign bus.empty       = empty_w;
    assign bus.full        = full_w;
    assign bus.almost_full = (count_q == AFULL_C);
    assign bus.overflow    = overflow_q;
    assign bus.underflow   = underflow_q;
endmodule

// File: tb/tb_lifo_stack_p.sv
// Drives a 12x5 and an 8x16 stack with the same directed commands, checks both against a queue model.
module tb_lifo_stack_p;
    logic clk;
    logic reset_n;
    bit   chk_en;
    int   n_pass;
    int   n_total;

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic        ov0, un0, ov1, un1;

    lifo_stack_p_if #(.WIDTH(12), .DEPTH(5))  bus0 ();
    lifo_stack_p_if #(.WIDTH(8),  .DEPTH(16)) bus1 ();

    lifo_stack_p #(.WIDTH(12), .DEPTH(5))  u0 (.clk(clk), .reset_n(reset_n), .bus(bus0));
    lifo_stack_p #(.WIDTH(8),  .DEPTH(16)) u1 (.clk(clk), .reset_n(reset_n), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total = n_total + 1;
        if (act === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic mstep(inout logic [31:0] q[$], inout logic ov, inout logic un,
                         input int depth, input bit clr, input bit psh, input bit pp,
                         input bit ec, input logic [31:0] d);
        bit ovs, uns;
        ovs = 1'b0;
        uns = 1'b0;
        if (clr) q.delete();
        else if (psh && pp) begin
            if (q.size() == 0) q.push_back(d);
            else q[q.size()-1] = d;
        end else if (psh) begin
            if (q.size() == depth) ovs = 1'b1;
            else q.push_back(d);
        end else if (pp) begin
            if (q.size() == 0) uns = 1'b1;
            else void'(q.pop_back());
        end
        ov = (ec ? 1'b0 : ov) | ovs;
        un = (ec ? 1'b0 : un) | uns;
    endtask

    task automatic drive(input bit clr, input bit psh, input bit pp, input bit ec, input logic [31:0] d);
        bus0.clear = clr;  bus0.push = psh;  bus0.pop = pp;  bus0.err_clr = ec;  bus0.data_in = d[11:0];
        bus1.clear = clr;  bus1.push = psh;  bus1.pop = pp;  bus1.err_clr = ec;  bus1.data_in = d[7:0];
    endtask

    task automatic step(input bit clr, input bit psh, input bit pp, input bit ec, input logic [31:0] d);
        drive(clr, psh, pp, ec, d);
        @(posedge clk);
        mstep(q0, ov0, un0, 5,  clr, psh, pp, ec, d & 32'hFFF);
        mstep(q1, ov1, un1, 16, clr, psh, pp, ec, d & 32'hFF);
        #1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        ov0 = 1'b0; un0 = 1'b0; ov1 = 1'b0; un1 = 1'b0;
    endtask

    function automatic logic [31:0] top_of(input logic [31:0] q[$]);
        return (q.size() == 0) ? 32'h0 : q[q.size()-1];
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("u0_count",     32'(bus0.count),       32'(q0.size()));
            check("u0_data_out",  32'(bus0.data_out),    top_of(q0));
            check("u0_empty",     32'(bus0.empty),       32'(q0.size() == 0));
            check("u0_full",      32'(bus0.full),        32'(q0.size() == 5));
            check("u0_afull",     32'(bus0.almost_full), 32'(q0.size() == 4));
            check("u0_overflow",  32'(bus0.overflow),    32'(ov0));
            check("u0_underflow", 32'(bus0.underflow),   32'(un0));
            check("u1_count",     32'(bus1.count),       32'(q1.size()));
            check("u1_data_out",  32'(bus1.data_out),    top_of(q1));
            check("u1_empty",     32'(bus1.empty),       32'(q1.size() == 0));
            check("u1_full",      32'(bus1.full),        32'(q1.size() == 16));
            check("u1_afull",     32'(bus1.almost_full), 32'(q1.size() == 15));
            check("u1_overflow",  32'(bus1.overflow),    32'(ov1));
            check("u1_underflow", 32'(bus1.underflow),   32'(un1));
        end
    end

    initial begin
        n_pass  = 0;
        n_total = 0;
        chk_en  = 1'b0;
        reset_n = 1'b0;
        model_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        #3;
        check("rst_count",    32'(bus0.count),    32'd0);
        check("rst_empty",    32'(bus0.empty),    32'd1);
        check("rst_data_out", 32'(bus0.data_out), 32'd0);
        #9 reset_n = 1'b1;
        chk_en = 1'b1;

        // basic push/pop
        step(0, 1, 0, 0, 32'h111);
        step(0, 1, 0, 0, 32'h222);
        step(0, 1, 0, 0, 32'h333);
        check("lit_cnt3",  32'(bus0.count),    32'd3);
        check("lit_top3",  32'(bus0.data_out), 32'h333);
        step(0, 0, 1, 0, 32'h0);
        check("lit_pop_top", 32'(bus0.data_out), 32'h222);
        check("lit_pop_cnt", 32'(bus0.count),    32'd2);

        // replace top
        step(0, 1, 0, 0, 32'h333);
        step(0, 1, 1, 0, 32'h777);
        check("lit_repl_cnt", 32'(bus0.count),    32'd3);
        check("lit_repl_top", 32'(bus0.data_out), 32'h777);

        // clear beats push
        step(0, 1, 0, 0, 32'h444);
        step(1, 1, 0, 0, 32'h999);
        check("lit_clr_cnt",  32'(bus0.count),    32'd0);
        check("lit_clr_data", 32'(bus0.data_out), 32'd0);

        // underflow and err_clr
        step(0, 0, 1, 0, 32'h0);
        check("lit_unf",      32'(bus0.underflow), 32'd1);
        step(0, 0, 1, 1, 32'h0);
        check("lit_unf_set_wins", 32'(bus0.underflow), 32'd1);
        step(0, 0, 0, 1, 32'h0);
        check("lit_unf_cleared", 32'(bus0.underflow), 32'd0);

        // push&pop on empty acts as push
        step(0, 1, 1, 0, 32'h055);
        check("lit_pp_empty_cnt", 32'(bus0.count),    32'd1);
        check("lit_pp_empty_top", 32'(bus0.data_out), 32'h055);

        // fill to full, then overflow
        step(1, 0, 0, 0, 32'h0);
        for (int i = 1; i <= 5; i++) begin
            step(0, 1, 0, 0, 32'hA00 + 32'(i));
            if (i == 4) check("lit_afull4", 32'(bus0.almost_full), 32'd1);
        end
        check("lit_full5", 32'(bus0.full), 32'd1);
        step(0, 1, 0, 0, 32'hABC);
        check("lit_ovf_cnt", 32'(bus0.count),    32'd5);
        check("lit_ovf_top", 32'(bus0.data_out), 32'hA05);
        check("lit_ovf",     32'(bus0.overflow), 32'd1);
        step(0, 1, 1, 0, 32'hBEE);
        step(1, 1, 0, 0, 32'h999);
        check("lit_clr_keeps_ovf", 32'(bus0.overflow), 32'd1);

        // asynchronous reset mid-cycle
        step(0, 1, 0, 0, 32'h111);
        step(0, 1, 0, 0, 32'h222);
        step(0, 1, 0, 0, 32'h333);
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        check("lit_arst_cnt",   32'(bus0.count),    32'd0);
        check("lit_arst_ovf",   32'(bus0.overflow), 32'd0);
        check("lit_arst_empty", 32'(bus0.empty),    32'd1);
        @(negedge clk);
        #2 reset_n = 1'b1;

        // rerun on the wide/deep instance
        step(0, 1, 0, 0, 32'h111);
        step(0, 1, 0, 0, 32'h222);
        step(0, 1, 0, 0, 32'h333);
        check("lit_u1_cnt3", 32'(bus1.count),    32'd3);
        check("lit_u1_top3", 32'(bus1.data_out), 32'h33);
        step(0, 0, 1, 0, 32'h0);
        check("lit_u1_pop_top", 32'(bus1.data_out), 32'h22);
        check("lit_u1_pop_cnt", 32'(bus1.count),    32'd2);

        step(1, 0, 0, 0, 32'h0);
        for (int i = 1; i <= 17; i++) begin
            step(0, 1, 0, 0, 32'h10 + 32'(i));
            if (i == 15) check("lit_u1_afull", 32'(bus1.almost_full), 32'd1);
            if (i == 16) check("lit_u1_full",  32'(bus1.full),        32'd1);
        end
        check("lit_u1_ovf", 32'(bus1.overflow), 32'd1);
        check("lit_u1_top", 32'(bus1.data_out), 32'h20);
        for (int i = 0; i < 17; i++) step(0, 0, 1, 0, 32'h0);
        check("lit_u1_unf", 32'(bus1.underflow), 32'd1);

        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
